multicycle_control_unit: RTL

Multi-cycle sequencer for the RV32I core: replaces single-cycle decode with an FSM that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. Memory accesses are held until the data bus acknowledges. It drives the same datapath control points as the current decode: ALU operation, ALU source mux, register-file write-back mux, bus write and branch. It adds a PC enable and a bus read strobe so the datapath registers update only on the final cycle of each instruction.

---
 rtl/multicycle_control_unit_pkg.sv | 66 ++++++
 rtl/multicycle_control_unit_control_decoder.sv | 93 +++++++++
 rtl/multicycle_control_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, ALU codes,
// write-back source codes, FSM states and instruction classes.
package defines;

    // RV32I base opcodes (instrCode[6:0])
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // ALU operation codes shared with the datapath: {bit30, funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Register-file write-back source select
    localparam logic [2:0] RFWD_ALU   = 3'd0;
    localparam logic [2:0] RFWD_BUS   = 3'd1;
    localparam logic [2:0] RFWD_IMM   = 3'd2;
    localparam logic [2:0] RFWD_AUIPC = 3'd3;
    localparam logic [2:0] RFWD_PC4   = 3'd4;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_L       = 4'd1,
        CLS_I       = 4'd2,
        CLS_S       = 4'd3,
        CLS_B       = 4'd4,
        CLS_LUI     = 4'd5,
        CLS_AUIPC   = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_t;

    // Classes that write the register file at the end of EXECUTE
    function automatic logic writes_in_execute(input instr_class_t cls);
        logic v;
        case (cls)
            CLS_R, CLS_I, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR: v = 1'b1;
            default:                                             v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_control_decoder.sv
// Purely combinational instruction decode: instruction class, ALU operation
// and datapath mux selects. Valid in every FSM state.
module control_decoder
    import defines::*;
(
    input  logic [31:0]  i_instr,
    output instr_class_t o_class,
    output logic [3:0]   o_alu_control,
    output logic         o_alu_src_sel,
    output logic [2:0]   o_rfwd_src_sel,
    output logic         o_jal,
    output logic         o_jalr
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_bit30;
    logic       w_unused_bits;

    assign w_opcode      = i_instr[6:0];
    assign w_funct3      = i_instr[14:12];
    assign w_bit30       = i_instr[30];
    // Register indices and immediates are consumed by the datapath, not here
    assign w_unused_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

    // Map the opcode onto an instruction class
    always_comb begin
        o_class = CLS_ILLEGAL;
        case (w_opcode)
            OP_R:     o_class = CLS_R;
            OP_L:     o_class = CLS_L;
            OP_I:     o_class = CLS_I;
            OP_S:     o_class = CLS_S;
            OP_B:     o_class = CLS_B;
            OP_LUI:   o_class = CLS_LUI;
            OP_AUIPC: o_class = CLS_AUIPC;
            OP_JAL:   o_class = CLS_JAL;
            OP_JALR:  o_class = CLS_JALR;
            default:  o_class = CLS_ILLEGAL;
        endcase
    end

    // Derive ALU operation and mux selects from the class and funct fields
    always_comb begin
        o_alu_control  = ALU_ADD;
        o_alu_src_sel  = 1'b0;
        o_rfwd_src_sel = RFWD_ALU;
        o_jal          = 1'b0;
        o_jalr         = 1'b0;
        case (o_class)
            CLS_R, CLS_B: begin
                o_alu_control = {w_bit30, w_funct3};
            end
            CLS_I: begin
                o_alu_src_sel = 1'b1;
                // Only the right shift uses bit30 to pick arithmetic vs logical
                if ((w_funct3 == 3'b101) && w_bit30) begin
                    o_alu_control = ALU_SRA;
                end else begin
                    o_alu_control = {1'b0, w_funct3};
                end
            end
            CLS_L: begin
                o_alu_src_sel  = 1'b1;
                o_rfwd_src_sel = RFWD_BUS;
            end
            CLS_S: begin
                o_alu_src_sel = 1'b1;
            end
            CLS_LUI: begin
                o_alu_src_sel  = 1'b1;
                o_rfwd_src_sel = RFWD_IMM;
            end
            CLS_AUIPC: begin
                o_alu_src_sel  = 1'b1;
                o_rfwd_src_sel = RFWD_AUIPC;
            end
            CLS_JAL: begin
                o_rfwd_src_sel = RFWD_PC4;
                o_jal          = 1'b1;
            end
            CLS_JALR: begin
                o_alu_src_sel  = 1'b1;
                o_rfwd_src_sel = RFWD_PC4;
                o_jalr         = 1'b1;
            end
            default: begin
                o_alu_control = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: steps each instruction through FETCH, DECODE,
// EXECUTE, MEM and WB, holding memory accesses until the bus acknowledges.
// Strobes are Moore on state plus instrCode; only pcEn in MEM also sees busReady.
module multicycle_control_unit
    import defines::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    input  logic        busReady,
    output logic        pcEn,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        busWe,
    output logic        busRe,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        illegalInstr
);

    state_t       r_state;
    state_t       w_next_state;
    instr_class_t w_class;
    logic         w_is_mem_op;

    control_decoder u_decoder (
        .i_instr        (instrCode),
        .o_class        (w_class),
        .o_alu_control  (aluControl),
        .o_alu_src_sel  (aluSrcMuxSel),
        .o_rfwd_src_sel (RFWDSrcMuxSel),
        .o_jal          (jal),
        .o_jalr         (jalr)
    );

    assign w_is_mem_op = (w_class == CLS_L) || (w_class == CLS_S);

    // State register; reset returns to FETCH without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH: begin
                w_next_state = DECODE;
            end
            DECODE: begin
                if (w_class == CLS_ILLEGAL) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = EXECUTE;
                end
            end
            EXECUTE: begin
                if (w_is_mem_op) begin
                    w_next_state = MEM;
                end else begin
                    w_next_state = FETCH;
                end
            end
            MEM: begin
                if (!busReady) begin
                    w_next_state = MEM;
                end else if (w_class == CLS_L) begin
                    w_next_state = WB;
                end else begin
                    w_next_state = FETCH;
                end
            end
            WB: begin
                w_next_state = FETCH;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    // State-gated strobes; pcEn marks the retiring cycle of each instruction
    always_comb begin
        pcEn         = 1'b0;
        regFileWe    = 1'b0;
        busWe        = 1'b0;
        busRe        = 1'b0;
        branch       = 1'b0;
        illegalInstr = 1'b0;
        case (r_state)
            FETCH: begin
                pcEn = 1'b0;
            end
            DECODE: begin
                if (w_class == CLS_ILLEGAL) begin
                    illegalInstr = 1'b1;
                    pcEn         = 1'b1;
                end else begin
                    illegalInstr = 1'b0;
                end
            end
            EXECUTE: begin
                regFileWe = writes_in_execute(w_class);
                branch    = (w_class == CLS_B);
                pcEn      = !w_is_mem_op;
            end
            MEM: begin
                busWe = (w_class == CLS_S);
                busRe = (w_class == CLS_L);
                pcEn  = busReady && (w_class == CLS_S);
            end
            WB: begin
                regFileWe = (w_class == CLS_L);
                pcEn      = 1'b1;
            end
            default: begin
                pcEn = 1'b0;
            end
        endcase
    end

endmodule
